// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM states and default widths.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int unsigned DIV_N     = 16;
  localparam int unsigned DIV_M     = 8;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_N + 1);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned M = 8
) (
  input  logic [M-1:0] rp,
  input  logic         msb,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] rp_next,
  output logic         q_bit
);

  logic [M:0]   p;
  logic [M-1:0] diff;

  always_comb begin
    p     = {rp, msb};
    q_bit = (p >= {1'b0, divisor});
    // When the subtract succeeds the true difference is below the divisor, so M bits hold it.
    diff    = p[M-1:0] - divisor;
    rp_next = q_bit ? diff : p[M-1:0];
  end

endmodule

// File: rtl/restoring_div_16.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional RESTORING_DIV_ZERO_CHECK_EN short-circuits a zero divisor and flags it.
module restoring_div_16
  import arith_pkg::*;
#(
  parameter int unsigned N = DIV_N,
  parameter int unsigned M = DIV_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Q,
  output logic [M-1:0] R,
  output logic         div_by_zero
);

  localparam int unsigned CntW = $clog2(N + 1);

  div_state_t    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [N-1:0]  dq_q, dq_d;
  logic [M-1:0]  dvs_q, dvs_d;
  // Only the low M bits of the partial remainder ever feed the next step.
  logic [M-1:0]  rp_q, rp_d;
  logic [M-1:0]  rp_next;
  logic          q_bit;

  div_step #(
    .M(M)
  ) u_div_step (
    .rp     (rp_q),
    .msb    (dq_q[N-1]),
    .divisor(dvs_q),
    .rp_next(rp_next),
    .q_bit  (q_bit)
  );

`ifdef RESTORING_DIV_ZERO_CHECK_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rp_d    = rp_q;
`ifdef RESTORING_DIV_ZERO_CHECK_EN
    dbz_d   = dbz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dq_d    = A;
          dvs_d   = B;
          rp_d    = '0;
          cnt_d   = CntW'(N);
          state_d = RUN;
`ifdef RESTORING_DIV_ZERO_CHECK_EN
          dbz_d   = (B == '0);
`endif
        end
      end
      RUN: begin
        dq_d  = {dq_q[N-2:0], q_bit};
        rp_d  = rp_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = DONE;
`ifdef RESTORING_DIV_ZERO_CHECK_EN
        // Zero divisor: produce the plain algorithm's result in one cycle.
        if (dbz_q) begin
          dq_d    = '1;
          rp_d    = dq_q[M-1:0];
          cnt_d   = '0;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      rp_q    <= rp_d;
    end
  end

`ifdef RESTORING_DIV_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbz_q <= 1'b0;
    else        dbz_q <= dbz_d;
  end
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = dq_q;
  assign R         = rp_q;

endmodule

// File: tb/tb_restoring_div_16.sv
// Directed bench for restoring_div_16 with an arithmetic reference model and a
// per-cycle result checker.
module tb_restoring_div_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_q;
  logic [7:0]  exp_r;
  logic        exp_dbz;
  logic        exp_live = 1'b0;

  restoring_div_16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: exact unsigned division, zero divisor yields all-ones and A[7:0].
  task automatic model(input logic [15:0] a, input logic [7:0] b);
    if (b == 8'd0) begin
      exp_q = 16'hFFFF;
      exp_r = a[7:0];
    end else begin
      exp_q = a / {8'd0, b};
      exp_r = 8'(a % {8'd0, b});
    end
`ifdef RESTORING_DIV_ZERO_CHECK_EN
    exp_dbz = (b == 8'd0);
`else
    exp_dbz = 1'b0;
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_live) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("model_q", 32'(Q), 32'(exp_q));
        check("model_r", 32'(R), 32'(exp_r));
        check("model_dbz", 32'(div_by_zero), 32'(exp_dbz));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
      end
    end
  end

  task automatic start(input logic [15:0] a, input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("wait_in_ready_timeout", 32'(in_ready), 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    model(a, b);
    exp_live = 1'b1;
    #1;
    in_valid = 1'b0;
    // Junk on the operand bus must not disturb the running division.
    A = 16'(~a);
    B = 8'hA5;
  endtask

  task automatic finish(input logic [15:0] a, input logic [7:0] b, input logic [15:0] lq,
                        input logic [7:0] lr, input int hold);
    int lat;
    int want_lat;
    want_lat = 16;
`ifdef RESTORING_DIV_ZERO_CHECK_EN
    if (b == 8'd0) want_lat = 1;
`endif
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid && in_ready) check("in_ready_in_run", 32'(in_ready), 32'd0);
    end while (!out_valid && lat < 40);
    check("latency", 32'(lat), 32'(want_lat));
    check("lit_q", 32'(Q), 32'(lq));
    check("lit_r", 32'(R), 32'(lr));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_keep_q", 32'(Q), 32'(lq));
    if (a == 16'd0) check("unused_a", 32'(a), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    int          hold;
  } vec_t;

  vec_t vecs[8] = '{
    '{16'd1000,  8'd7,   16'd142,   8'd6,   0},
    '{16'hFFFF,  8'hFF,  16'd257,   8'd0,   0},
    '{16'd5,     8'd9,   16'd0,     8'd5,   0},
    '{16'd300,   8'd1,   16'd300,   8'd0,   5},
    '{16'h1234,  8'd0,   16'hFFFF,  8'h34,  2},
    '{16'd12345, 8'd200, 16'd61,    8'd145, 0},
    '{16'd100,   8'd255, 16'd0,     8'd100, 1},
    '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   0}
  };

  initial begin
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(Q), 32'd0);
    check("rst_r", 32'(R), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b);
      finish(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].hold);
    end

    // Abort a division partway through RUN.
    start(16'd1000, 8'd7);
    repeat (8) @(posedge clk);
    #1;
    exp_live = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_q", 32'(Q), 32'd0);
    check("abort_r", 32'(R), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_stays_idle", 32'(in_ready), 32'd1);
    start(16'd77, 8'd10);
    finish(16'd77, 8'd10, 16'd7, 8'd7, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
